// File: rtl/axi_ni_request_tracker.sv
// Per-ID AXI request tracker for the NI: admits decoded requests, pushes the response route, counts outstanding.
// Optional source-lock admission filter enabled with macro NI_TRACKER_LOCK_EN.
`ifndef AXIIDWD
`define AXIIDWD 4
`endif
`ifndef SOURCEWD
`define SOURCEWD 8
`endif

module axi_ni_request_tracker #(
    parameter int unsigned MAX_SUPPORTED_IDS = 16,
    parameter logic [MAX_SUPPORTED_IDS-1:0] ID_MAP = MAX_SUPPORTED_IDS'(16'hFFFF),
    parameter int unsigned LOG_MAX_OUTSTANDING = 4
) (
    input  logic                         noc_clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_is_read,
    input  logic [`AXIIDWD-1:0]          req_id,
    input  logic [`SOURCEWD-1:0]         req_source,
    input  logic                         req_locked,
    output logic                         new_packet_type_is_read,
    output logic [`SOURCEWD-1:0]         new_message_source,
    output logic                         new_message_is_locked,
    output logic [MAX_SUPPORTED_IDS-1:0] wrr_winc,
    output logic [MAX_SUPPORTED_IDS-1:0] rdr_winc,
    input  logic [MAX_SUPPORTED_IDS-1:0] wrr_wfull,
    input  logic [MAX_SUPPORTED_IDS-1:0] rdr_wfull,
    input  logic [MAX_SUPPORTED_IDS-1:0] resp_done,
    output logic                         idle,
    output logic                         count_err
);

    localparam int unsigned N     = MAX_SUPPORTED_IDS;
    localparam int unsigned CNT_W = LOG_MAX_OUTSTANDING + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(1 << LOG_MAX_OUTSTANDING);

    typedef enum logic {IDLE = 1'b0, PUSH = 1'b1} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_next [N];
    logic [CNT_W-1:0] cnt_sel;
    logic [N-1:0]     id_sel;
    logic [N-1:0]     push_vec;
    logic             map_ok;
    logic             fifo_full;
    logic             lock_ok;
    logic             accept;
    logic             err_next;
    logic             idle_next;
    logic             all_zero;

    assign id_sel    = N'(1) << req_id;
    assign map_ok    = |(ID_MAP & id_sel);
    assign fifo_full = req_is_read ? |(rdr_wfull & id_sel) : |(wrr_wfull & id_sel);
    assign push_vec  = wrr_winc | rdr_winc;
    assign accept    = req_valid && req_ready;

`ifdef NI_TRACKER_LOCK_EN
    logic                 lock_active;
    logic [`SOURCEWD-1:0] lock_owner;

    assign lock_ok = !lock_active || (req_source == lock_owner);

    // Lock is taken by a locked accept and released by the owner's next unlocked accept.
    always_ff @(posedge noc_clk or posedge rst) begin
        if (rst) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (accept) begin
            if (req_locked) begin
                lock_active <= 1'b1;
                lock_owner  <= req_source;
            end else if (lock_active && (req_source == lock_owner)) begin
                lock_active <= 1'b0;
            end
        end
    end
`else
    assign lock_ok = 1'b1;
`endif

    always_ff @(posedge noc_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        err_next   = count_err;
        all_zero   = 1'b1;
        cnt_sel    = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (id_sel[i]) cnt_sel = cnt[i];
        end
        if (state == IDLE) begin
            req_ready = map_ok && !fifo_full && (cnt_sel < CNT_LIMIT) && lock_ok;
            if (req_valid && req_ready) state_next = PUSH;
        end else begin
            state_next = IDLE;
        end
        // A push and a retire on the same ID cancel out.
        for (int i = 0; i < int'(N); i++) begin
            cnt_next[i] = cnt[i];
            if (push_vec[i] && !resp_done[i]) begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end else if (!push_vec[i] && resp_done[i]) begin
                if (cnt[i] == '0) err_next = 1'b1;
                else              cnt_next[i] = cnt[i] - CNT_W'(1);
            end
            if (cnt_next[i] != '0) all_zero = 1'b0;
        end
        idle_next = (state_next == IDLE) && all_zero;
    end

    // Datapath registers; winc is armed on accept so it pulses during PUSH only.
    always_ff @(posedge noc_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) cnt[i] <= '0;
            count_err               <= 1'b0;
            idle                    <= 1'b1;
            wrr_winc                <= '0;
            rdr_winc                <= '0;
            new_packet_type_is_read <= 1'b0;
            new_message_source      <= '0;
            new_message_is_locked   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(N); i++) cnt[i] <= cnt_next[i];
            count_err <= err_next;
            idle      <= idle_next;
            wrr_winc  <= (accept && !req_is_read) ? id_sel : '0;
            rdr_winc  <= (accept &&  req_is_read) ? id_sel : '0;
            if (accept) begin
                new_packet_type_is_read <= req_is_read;
                new_message_source      <= req_source;
                new_message_is_locked   <= req_locked;
            end
        end
    end

endmodule

// File: tb/tb_axi_ni_request_tracker.sv
// Scoreboard bench for axi_ni_request_tracker: directed scenarios followed by random traffic.
`ifndef AXIIDWD
`define AXIIDWD 4
`endif
`ifndef SOURCEWD
`define SOURCEWD 8
`endif

module tb_axi_ni_request_tracker;

    localparam int unsigned N     = 16;
    localparam int unsigned LIMIT = 16;
    localparam int unsigned ID_W  = `AXIIDWD;
    localparam int unsigned SRC_W = `SOURCEWD;
    localparam logic [N-1:0] MAP  = 16'h7FFF;

    logic              noc_clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_is_read;
    logic [ID_W-1:0]   req_id;
    logic [SRC_W-1:0]  req_source;
    logic              req_locked;
    logic              new_packet_type_is_read;
    logic [SRC_W-1:0]  new_message_source;
    logic              new_message_is_locked;
    logic [N-1:0]      wrr_winc;
    logic [N-1:0]      rdr_winc;
    logic [N-1:0]      wrr_wfull;
    logic [N-1:0]      rdr_wfull;
    logic [N-1:0]      resp_done;
    logic              idle;
    logic              count_err;

    axi_ni_request_tracker #(
        .MAX_SUPPORTED_IDS(N),
        .ID_MAP(MAP),
        .LOG_MAX_OUTSTANDING(4)
    ) dut (
        .noc_clk(noc_clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_is_read(req_is_read),
        .req_id(req_id),
        .req_source(req_source),
        .req_locked(req_locked),
        .new_packet_type_is_read(new_packet_type_is_read),
        .new_message_source(new_message_source),
        .new_message_is_locked(new_message_is_locked),
        .wrr_winc(wrr_winc),
        .rdr_winc(rdr_winc),
        .wrr_wfull(wrr_wfull),
        .rdr_wfull(rdr_wfull),
        .resp_done(resp_done),
        .idle(idle),
        .count_err(count_err)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    typedef struct {
        logic [N-1:0] wr;
        logic [N-1:0] rd;
    } push_t;

    push_t            exp_q[$];
    int               outstanding[N];
    bit               busy_m;
    int               pend_id;
    bit               err_m;
    bit               acc_m;
    bit               last_rd;
    bit               last_lk;
    logic [SRC_W-1:0] last_src;
    bit               lk_act_m;
    logic [SRC_W-1:0] lk_own_m;
    int               vectors;
    int               miscompares;

    // Admission rule from the current request fields and the model's bookkeeping.
    function automatic bit ready_m();
        logic [N-1:0] m;
        bit full;
        int id;
        m  = MAP;
        id = int'(req_id);
        full = req_is_read ? rdr_wfull[id] : wrr_wfull[id];
        ready_m = !busy_m && m[id] && !full && (outstanding[id] < int'(LIMIT));
`ifdef NI_TRACKER_LOCK_EN
        if (lk_act_m && (req_source != lk_own_m)) ready_m = 1'b0;
`endif
    endfunction

    function automatic bit idle_m();
        idle_m = !busy_m;
        for (int i = 0; i < int'(N); i++) if (outstanding[i] != 0) idle_m = 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on each clock edge from the driven inputs only.
    always @(posedge noc_clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) outstanding[i] = 0;
            busy_m = 0; pend_id = 0; err_m = 0; acc_m = 0;
            last_rd = 0; last_lk = 0; last_src = '0;
            lk_act_m = 0; lk_own_m = '0;
            exp_q.delete();
        end else begin
            bit acc;
            acc = req_valid && ready_m();
            for (int i = 0; i < int'(N); i++) begin
                bit inc;
                inc = busy_m && (pend_id == i);
                if (inc && !resp_done[i]) outstanding[i]++;
                else if (!inc && resp_done[i]) begin
                    if (outstanding[i] == 0) err_m = 1;
                    else outstanding[i]--;
                end
            end
            if (acc) begin
                push_t e;
                e.wr = '0;
                e.rd = '0;
                if (req_is_read) e.rd[int'(req_id)] = 1'b1;
                else             e.wr[int'(req_id)] = 1'b1;
                exp_q.push_back(e);
                pend_id  = int'(req_id);
                last_rd  = req_is_read;
                last_lk  = req_locked;
                last_src = req_source;
                if (req_locked) begin
                    lk_act_m = 1;
                    lk_own_m = req_source;
                end else if (lk_act_m && req_source == lk_own_m) begin
                    lk_act_m = 0;
                end
            end
            busy_m = acc;
            acc_m  = acc;
        end
    end

    // Monitor: compares every presented output on the falling edge.
    always @(negedge noc_clk) begin
        if (!rst) begin
            chk("req_ready", 32'(req_ready), 32'(ready_m()));
            chk("idle", 32'(idle), 32'(idle_m()));
            chk("count_err", 32'(count_err), 32'(err_m));
            chk("new_type", 32'(new_packet_type_is_read), 32'(last_rd));
            chk("new_locked", 32'(new_message_is_locked), 32'(last_lk));
            chk("new_source", 32'(new_message_source), 32'(last_src));
            if ((wrr_winc | rdr_winc) != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_winc", 32'(wrr_winc | rdr_winc), 32'd0);
                end else begin
                    push_t e;
                    e = exp_q.pop_front();
                    chk("wrr_winc", 32'(wrr_winc), 32'(e.wr));
                    chk("rdr_winc", 32'(rdr_winc), 32'(e.rd));
                end
            end else if (busy_m) begin
                chk("missing_winc", 32'(wrr_winc | rdr_winc), 32'(1) << pend_id);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic set_req(input bit rd, input int id, input int src, input bit lk);
        req_valid   = 1'b1;
        req_is_read = rd;
        req_id      = ID_W'(id);
        req_source  = SRC_W'(src);
        req_locked  = lk;
    endtask

    // Hold a request until the model sees it accepted; returns inside the PUSH cycle.
    task automatic send(input bit rd, input int id, input int src, input bit lk, input int budget);
        bit done;
        done = 0;
        set_req(rd, id, src, lk);
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = acc_m;
        end
        req_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            for (int k = 0; k < 40 && outstanding[i] > 0; k++) begin
                resp_done = N'(1) << i;
                step();
            end
        end
        resp_done = '0;
        step();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; req_valid = 0; req_is_read = 0; req_id = '0; req_source = '0;
        req_locked = 0; wrr_wfull = '0; rdr_wfull = '0; resp_done = '0;
        repeat (2) @(posedge noc_clk);
        #1 rst = 1'b0;
        @(negedge noc_clk);
        chk("reset_idle", 32'(idle), 32'd1);
        chk("reset_winc", 32'(wrr_winc | rdr_winc), 32'd0);
        chk("reset_source", 32'(new_message_source), 32'd0);
        step();

        // Single write to id 3.
        send(0, 3, 8'h05, 0, 4);
        @(negedge noc_clk);
        chk("single_wr_winc", 32'(wrr_winc), 32'h0008);
        @(negedge noc_clk);
        chk("single_wr_pulse_end", 32'(wrr_winc), 32'h0);
        chk("single_wr_idle", 32'(idle), 32'd0);
        chk("single_wr_src", 32'(new_message_source), 32'h05);
        step();
        drain();

        // Sixteen reads fill id 2, the 17th stalls until one retires.
        for (int k = 0; k < 16; k++) send(1, 2, 8'h11, 0, 4);
        set_req(1, 2, 8'h11, 0);
        repeat (4) step();
        chk("limit_stall", 32'(acc_m), 32'd0);
        resp_done = 16'h0004;
        step();
        resp_done = '0;
        send(1, 2, 8'h11, 0, 4);
        step();
        drain();

        // Full read-route FIFO blocks id 7.
        rdr_wfull = 16'h0080;
        set_req(1, 7, 8'h01, 0);
        repeat (3) step();
        chk("full_stall", 32'(acc_m), 32'd0);
        rdr_wfull = '0;
        send(1, 7, 8'h01, 0, 4);
        @(negedge noc_clk);
        chk("full_release_winc", 32'(rdr_winc), 32'h0080);
        step();

        // Retire coincident with push on id 1, then an underflow on id 4.
        send(0, 1, 8'h02, 0, 4);
        send(0, 1, 8'h02, 0, 4);
        send(0, 1, 8'h02, 0, 4);
        resp_done = 16'h0002;
        step();
        resp_done = 16'h0010;
        step();
        resp_done = '0;
        step();
        chk("underflow_err", 32'(count_err), 32'd1);
        drain();

        // Locked request from 0x09, competing source 0x0A.
        send(0, 5, 8'h09, 1, 4);
`ifdef NI_TRACKER_LOCK_EN
        set_req(0, 5, 8'h0A, 0);
        repeat (4) step();
        chk("lock_stall", 32'(acc_m), 32'd0);
        send(0, 5, 8'h09, 0, 4);
        send(0, 5, 8'h0A, 0, 4);
`else
        send(0, 5, 8'h0A, 0, 2);
`endif
        step();
        drain();

        // Reset while in PUSH suppresses the push.
        send(1, 6, 8'h03, 0, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge noc_clk);
        chk("rst_push_winc", 32'(wrr_winc | rdr_winc), 32'd0);
        chk("rst_push_idle", 32'(idle), 32'd1);
        chk("rst_push_err", 32'(count_err), 32'd0);
        step();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            int id;
            req_valid   = ($urandom % 4) != 0;
            req_is_read = $urandom % 2;
            req_id      = ID_W'($urandom % N);
            case ($urandom % 3)
                0:       req_source = SRC_W'(8'h05);
                1:       req_source = SRC_W'(8'h09);
                default: req_source = SRC_W'(8'h0A);
            endcase
            req_locked = ($urandom % 8) == 0;
            for (int i = 0; i < int'(N); i++) begin
                wrr_wfull[i] = ($urandom % 8) == 0;
                rdr_wfull[i] = ($urandom % 8) == 0;
            end
            resp_done = '0;
            if (($urandom % 3) == 0) begin
                id = int'($urandom % N);
                if (outstanding[id] > 0 || ($urandom % 50) == 0) resp_done = N'(1) << id;
            end
            step();
        end

        wrr_wfull = '0;
        rdr_wfull = '0;
        drain();
        @(negedge noc_clk);
        chk("final_idle", 32'(idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_ni_request_tracker.md
AXI_NI_REQUEST_TRACKER -- requirements
Module: axi_ni_request_tracker

Interface
REQ-001 SHALL have parameter MAX_SUPPORTED_IDS, default 16, number of AXI ID slots tracked.
REQ-002 SHALL have parameter ID_MAP, default 16'hFFFF, bitmask of implemented IDs; requests to unmapped IDs are never accepted.
REQ-003 SHALL have parameter LOG_MAX_OUTSTANDING, default 4, log2 of the per-ID outstanding-transaction limit.
REQ-004 SHALL have ports:
- noc_clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  decoded request header available.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_is_read  in  1  request type: 1 = read, 0 = write.
- req_id  in  `AXIIDWD  AXI ID of the request.
- req_source  in  `SOURCEWD  NoC source address of the request.
- req_locked  in  1  locked/exclusive request.
- new_packet_type_is_read  out  1  registered request type.
- new_message_source  out  `SOURCEWD  registered source, write data for the response-route FIFOs.
- new_message_is_locked  out  1  registered lock bit, write data for the response-route FIFOs.
- wrr_winc  out  MAX_SUPPORTED_IDS  one-hot push into the write-route FIFO.
- rdr_winc  out  MAX_SUPPORTED_IDS  one-hot push into the read-route FIFO.
- wrr_wfull  in  MAX_SUPPORTED_IDS  write-route FIFO full, per ID.
- rdr_wfull  in  MAX_SUPPORTED_IDS  read-route FIFO full, per ID.
- resp_done  in  MAX_SUPPORTED_IDS  response retired, per ID; one-hot (wrr_rinc|rdr_rinc).
- idle  out  1  no outstanding transactions and FSM in IDLE.
- count_err  out  1  sticky: resp_done seen for an ID whose count is 0.

Function
REQ-005 FSM SHALL have states IDLE and PUSH; IDLE->PUSH on accept; PUSH->IDLE unconditionally after one cycle.
REQ-006 req_ready SHALL be high only when all of the following hold: state is IDLE; ID_MAP[req_id]=1; the selected FIFO (rdr_wfull or wrr_wfull, chosen by req_is_read) is not full at req_id; cnt[req_id] < 2^LOG_MAX_OUTSTANDING; lock permits (REQ-012).
REQ-007 req_ready SHALL be combinational from the current state, the FIFO full flags, the counters, the lock state and the req_* inputs, and SHALL NOT depend on req_valid.
REQ-008 On accept, new_packet_type_is_read, new_message_source and new_message_is_locked SHALL register the req_* values and hold them until the next accept.
REQ-009 In PUSH, exactly one bit SHALL pulse for one cycle: rdr_winc[id] if type is read, else wrr_winc[id]; latency is accept + 1 cycle; peak throughput is one request per 2 cycles.
REQ-010 Per-ID counter cnt[i] SHALL be LOG_MAX_OUTSTANDING+1 bits wide and SHALL be incremented on the winc pulse and decremented on resp_done[i].
- Simultaneous increment and decrement on the same ID: count unchanged.
- Decrement at 0: count stays 0 and count_err is set.
REQ-011 idle SHALL be 1 when all cnt are 0 and state is IDLE; it is registered-state-derived only.

Reset
REQ-013 rst SHALL asynchronously force:
- state = IDLE, all cnt = 0, lock cleared, count_err = 0.
- all new_* outputs = 0, all winc outputs = 0.
- idle = 1; req_ready follows from the reset state.
REQ-014 Reset asserted during PUSH SHALL suppress the pending winc pulse, so no FIFO push occurs.

Configuration
REQ-012 With macro NI_TRACKER_LOCK_EN defined, the block SHALL hold lock_active and lock_owner[`SOURCEWD]:
- An accepted request with req_locked=1 sets lock_active and lock_owner = req_source.
- While lock_active is set, requests with req_source != lock_owner are not accepted.
- An accepted request from lock_owner with req_locked=0 clears lock_active.
REQ-015 Without NI_TRACKER_LOCK_EN, the lock term of REQ-006 SHALL be constant 1 and no lock registers SHALL exist. new_message_is_locked is still passed through as registered.

Verification
REQ-016 Single write, id 3, source 0x05 -> accept at cycle T; wrr_winc = 16'h0008 at T+1 only; new_message_source = 0x05; cnt[3] = 1; idle = 0.
REQ-017 Sixteen reads on id 2 with resp_done idle -> 16 accepts; 17th request sees req_ready = 0 with req_valid held; one resp_done[2] -> 17th request accepted.
REQ-018 rdr_wfull[7] = 1, read request on id 7 -> req_ready = 0; deassert full -> accept on the next IDLE cycle; rdr_winc[7] pulses one cycle later.
REQ-019 resp_done[1] coincident with the wrr_winc[1] pulse while cnt[1] = 2 -> cnt[1] stays 2; resp_done[4] with cnt[4] = 0 -> count_err = 1 and stays 1 until rst.
REQ-020 NI_TRACKER_LOCK_EN defined: locked request from source 0x09 accepted; request from 0x0A stalls; unlocked request from 0x09 accepted, then 0x0A accepted. Without the macro, 0x0A is accepted immediately.
REQ-021 rst pulse in PUSH -> no winc pulse; all counters 0; idle = 1 in the cycle after rst deasserts.
